// File: rtl/hub75_fbw_ctrl_if.sv
// hub75_fbw_ctrl_if
//   Bundles the pixel stream (valid/ready), the hub75_top frame-buffer write
//   port (fbw_*), the frame swap handshake and the status pulses.
//   master : controller side (accepts pixels, drives fbw_*/frame_swap/stat_*)
//   slave  : environment side (pixel source plus hub75_top)
interface hub75_fbw_ctrl_if #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
);
  logic [BITDEPTH-1:0]    in_data;
  logic                   in_sof;
  logic                   in_valid;
  logic                   in_ready;
  logic [LOG_N_BANKS-1:0] fbw_bank_addr;
  logic [LOG_N_ROWS-1:0]  fbw_row_addr;
  logic                   fbw_row_store;
  logic                   fbw_row_rdy;
  logic                   fbw_row_swap;
  logic [BITDEPTH-1:0]    fbw_data;
  logic [LOG_N_COLS-1:0]  fbw_col_addr;
  logic                   fbw_wren;
  logic                   frame_swap;
  logic                   frame_rdy;
  logic                   stat_frame;
  logic                   stat_resync;

  modport master (
    input  in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
    output in_ready, fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
           fbw_data, fbw_col_addr, fbw_wren, frame_swap, stat_frame, stat_resync
  );

  modport slave (
    output in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
    input  in_ready, fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
           fbw_data, fbw_col_addr, fbw_wren, frame_swap, stat_frame, stat_resync
  );
endinterface

// File: rtl/hub75_fbw_ctrl.sv
// hub75_fbw_ctrl
//   Feeds the hub75_top line buffer from a raster pixel stream, then swaps and
//   stores each completed line to (bank,row). After the last line it requests
//   a frame swap and holds off the stream until hub75_top reports it done.
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : hub75_fbw_ctrl_if.master (pixel stream, fbw_* write port,
//          frame_swap/frame_rdy, stat_frame/stat_resync pulses)
//
// state      | meaning
// LOAD       | accept pixels into the line buffer
// WAIT_ROW   | line full, wait for framebuffer ready
// SWAP       | line-buffer swap pulse
// STORE      | store pulse to (bank,row), advance line
// WAIT_LAST  | last line stored, wait for framebuffer ready
// FSWAP      | frame swap request pulse
// WAIT_FRAME | wait for hub75_top to finish the frame swap
module hub75_fbw_ctrl #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input logic              clk,
  input logic              rst,
  hub75_fbw_ctrl_if.master bus
);
  localparam int LINE_W = LOG_N_BANKS + LOG_N_ROWS;
  localparam logic [LINE_W-1:0]     LAST_LINE = LINE_W'(N_BANKS * N_ROWS - 1);
  localparam logic [LOG_N_COLS-1:0] LAST_COL  = LOG_N_COLS'(N_COLS - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_WAIT_ROW, S_SWAP, S_STORE, S_WAIT_LAST, S_FSWAP, S_WAIT_FRAME
  } state_t;

  state_t                state, state_nxt;
  logic [LINE_W-1:0]     line, line_nxt;
  logic [LOG_N_COLS-1:0] col, col_nxt, wcol_nxt;
  logic                  guard;
  logic                  accept;
  logic                  resync;
  logic                  frame_done;

  assign bus.in_ready = (state == S_LOAD) & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  // A frame start anywhere but (0,0) restarts the frame at this pixel.
  assign resync       = bus.in_sof & ((line != '0) | (col != '0));

  always_comb begin
    state_nxt  = state;
    line_nxt   = line;
    col_nxt    = col;
    wcol_nxt   = col;
    frame_done = 1'b0;
    case (state)
      S_LOAD: begin
        if (accept) begin
          if (resync) begin
            wcol_nxt = '0;
            col_nxt  = LOG_N_COLS'(1);
            line_nxt = '0;
          end else if (col == LAST_COL) begin
            col_nxt   = '0;
            state_nxt = S_WAIT_ROW;
          end else begin
            col_nxt = col + LOG_N_COLS'(1);
          end
        end
      end
      // guard masks a rdy that has not yet dropped in response to our last pulse
      S_WAIT_ROW:  if (bus.fbw_row_rdy & ~guard) state_nxt = S_SWAP;
      S_SWAP:      state_nxt = S_STORE;
      S_STORE: begin
        if (line == LAST_LINE) begin
          state_nxt = S_WAIT_LAST;
        end else begin
          line_nxt  = line + LINE_W'(1);
          state_nxt = S_LOAD;
        end
      end
      S_WAIT_LAST: if (bus.fbw_row_rdy & ~guard) state_nxt = S_FSWAP;
      S_FSWAP:     state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (bus.frame_rdy & ~guard) begin
          state_nxt  = S_LOAD;
          line_nxt   = '0;
          col_nxt    = '0;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_LOAD;
      line              <= '0;
      col               <= '0;
      guard             <= 1'b0;
      bus.fbw_wren      <= 1'b0;
      bus.fbw_data      <= '0;
      bus.fbw_col_addr  <= '0;
      bus.fbw_row_swap  <= 1'b0;
      bus.fbw_row_store <= 1'b0;
      bus.fbw_bank_addr <= '0;
      bus.fbw_row_addr  <= '0;
      bus.frame_swap    <= 1'b0;
      bus.stat_frame    <= 1'b0;
      bus.stat_resync   <= 1'b0;
    end else begin
      state        <= state_nxt;
      line         <= line_nxt;
      col          <= col_nxt;
      guard        <= bus.fbw_row_store | bus.frame_swap;
      bus.fbw_wren <= accept;
      if (accept) begin
        bus.fbw_data     <= bus.in_data;
        bus.fbw_col_addr <= wcol_nxt;
      end
      // Pulses are registered off the next state so they line up with it.
      bus.fbw_row_swap  <= (state_nxt == S_SWAP);
      bus.fbw_row_store <= (state_nxt == S_STORE);
      if (state_nxt == S_STORE) {bus.fbw_bank_addr, bus.fbw_row_addr} <= line;
      bus.frame_swap    <= (state_nxt == S_FSWAP);
      bus.stat_frame    <= frame_done;
      bus.stat_resync   <= accept & resync;
    end
  end
endmodule

// File: tb/tb_hub75_fbw_ctrl.sv
// tb_hub75_fbw_ctrl
//   Scoreboard bench for hub75_fbw_ctrl with a 2x4x8 panel geometry.
//   Accepted pixels push expected writes/stores; a monitor pops and compares.
`timescale 1ns/1ps
module tb_hub75_fbw_ctrl;
  localparam int N_BANKS  = 2;
  localparam int N_ROWS   = 4;
  localparam int N_COLS   = 8;
  localparam int BITDEPTH = 24;
  localparam int N_LINES  = N_BANKS * N_ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hub75_fbw_ctrl_if #(.N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                      .BITDEPTH(BITDEPTH)) bus ();

  hub75_fbw_ctrl #(.N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                   .BITDEPTH(BITDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] data;
    logic [2:0]  col;
    int          cyc;
  } wr_t;

  wr_t        wq[$];
  logic [2:0] sq[$];

  int checks = 0, errors = 0;
  int mon_cyc = 0;
  int n_swap = 0, n_store = 0, n_fswap = 0, n_sframe = 0, n_resync = 0;
  int exp_fswap = 0, exp_resync = 0;
  int mline = 0, mcol = 0;
  logic prev_swap = 1'b0;

  // ---------------- monitor ----------------
  initial begin
    wr_t        e;
    logic [2:0] el;
    forever begin
      @(posedge clk); #1;
      mon_cyc++;
      if (bus.fbw_wren === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got data=%h col=%0d, required no write",
                   bus.fbw_data, bus.fbw_col_addr);
        end else begin
          e = wq.pop_front();
          if (bus.fbw_data !== e.data || bus.fbw_col_addr !== e.col || mon_cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got data=%h col=%0d cyc=%0d, required data=%h col=%0d cyc=%0d",
                     bus.fbw_data, bus.fbw_col_addr, mon_cyc, e.data, e.col, e.cyc);
          end
        end
      end
      if (bus.fbw_row_store === 1'b1) begin
        n_store++;
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL store_unexpected: got bank=%0d row=%0d, required no store",
                   bus.fbw_bank_addr, bus.fbw_row_addr);
        end else begin
          el = sq.pop_front();
          if ({bus.fbw_bank_addr, bus.fbw_row_addr} !== el || prev_swap !== 1'b1) begin
            errors++;
            $display("FAIL store: got bank=%0d row=%0d swap_before=%0b, required bank=%0d row=%0d swap_before=1",
                     bus.fbw_bank_addr, bus.fbw_row_addr, prev_swap, el[2], el[1:0]);
          end
        end
      end
      if (bus.fbw_row_swap === 1'b1) n_swap++;
      if (bus.frame_swap === 1'b1)   n_fswap++;
      if (bus.stat_frame === 1'b1)   n_sframe++;
      if (bus.stat_resync === 1'b1)  n_resync++;
      prev_swap = bus.fbw_row_swap;
    end
  end

  // ---------------- reference model / driver ----------------
  task automatic model_accept(input logic [23:0] d, input logic sof);
    wr_t e;
    e.data = d;
    e.cyc  = mon_cyc + 1;
    if (sof && (mline != 0 || mcol != 0)) begin
      e.col = 3'd0;
      mline = 0;
      mcol  = 1;
      exp_resync++;
    end else begin
      e.col = mcol[2:0];
      if (mcol == N_COLS - 1) begin
        sq.push_back(mline[2:0]);
        mcol = 0;
        if (mline == N_LINES - 1) begin
          mline = 0;
          exp_fswap++;
        end else begin
          mline++;
        end
      end else begin
        mcol++;
      end
    end
    wq.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_px(input logic [23:0] d, input logic sof);
    bit done;
    int budget;
    done = 0;
    budget = 0;
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        model_accept(d, sof);
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) begin
        budget++;
        if (budget > 300) begin
          checks++;
          errors++;
          $display("FAIL handshake_timeout: got in_ready=0 for 300 cycles, required handshake");
          done = 1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_pixels(input int n, input logic [23:0] base, input logic sof_first,
                             input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_px(base + 24'(i), sof_first && (i == 0));
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_frame_done(input int sf0, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (n_sframe > sf0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_stat_frame: got no stat_frame in 200 cycles, required one", name);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_data = '0; bus.in_sof = 1'b0; bus.in_valid = 1'b0;
    bus.fbw_row_rdy = 1'b1; bus.frame_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.fbw_wren, bus.fbw_row_swap, bus.fbw_row_store, bus.frame_swap,
         bus.stat_frame, bus.stat_resync, bus.fbw_bank_addr, bus.fbw_row_addr,
         bus.fbw_col_addr, bus.fbw_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b wren=%b swap=%b store=%b fswap=%b data=%h, required all 0",
               bus.in_ready, bus.fbw_wren, bus.fbw_row_swap, bus.fbw_row_store, bus.frame_swap, bus.fbw_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    int s0, w0, f0, sf0;
    s0 = n_store; w0 = n_swap; f0 = n_fswap; sf0 = n_sframe;
    send_pixels(64, 24'h100000, 1'b1, 1'b0);
    wait_frame_done(sf0, "full_frame");
    checks++;
    if (n_store - s0 != 8 || n_swap - w0 != 8 || n_fswap - f0 != 1 || n_sframe - sf0 != 1) begin
      errors++;
      $display("FAIL full_frame_counts: got stores=%0d swaps=%0d fswaps=%0d sframes=%0d, required 8 8 1 1",
               n_store - s0, n_swap - w0, n_fswap - f0, n_sframe - sf0);
    end
  endtask

  task automatic test_row_rdy_stall();
    int w0, s0, sf0;
    bit bad;
    w0 = n_swap; s0 = n_store; sf0 = n_sframe; bad = 0;
    bus.fbw_row_rdy = 1'b0;
    send_pixels(8, 24'h200000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || n_swap != w0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL row_rdy_stall: got ready=%b swaps=%0d during stall, required ready=0 swaps=0",
               bus.in_ready, n_swap - w0);
    end
    bus.fbw_row_rdy = 1'b1;
    @(posedge clk); #1;
    send_pixels(56, 24'h200008, 1'b0, 1'b0);
    wait_frame_done(sf0, "row_rdy_stall");
    checks++;
    if (n_store - s0 != 8) begin
      errors++;
      $display("FAIL row_rdy_stall_stores: got %0d, required 8", n_store - s0);
    end
  endtask

  task automatic test_resync();
    int r0, sf0;
    r0 = n_resync; sf0 = n_sframe;
    send_pixels(13, 24'h300000, 1'b1, 1'b0);
    send_px(24'h30000D, 1'b1);
    send_pixels(63, 24'h30000E, 1'b0, 1'b0);
    wait_frame_done(sf0, "resync");
    checks++;
    if (n_resync - r0 != 1) begin
      errors++;
      $display("FAIL resync_pulse: got %0d pulses, required 1", n_resync - r0);
    end
  endtask

  task automatic test_frame_rdy_stall();
    int f0, sf0;
    bit seen, bad;
    f0 = n_fswap; sf0 = n_sframe; seen = 0; bad = 0;
    bus.frame_rdy = 1'b0;
    send_pixels(64, 24'h400000, 1'b1, 1'b0);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (n_fswap > f0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_swap_seen: got no frame_swap in 100 cycles, required one");
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || n_sframe != sf0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL frame_rdy_stall: got ready=%b sframes=%0d, required ready=0 sframes=0",
               bus.in_ready, n_sframe - sf0);
    end
    bus.frame_rdy = 1'b1;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n_sframe - sf0 != 1) begin
      errors++;
      $display("FAIL frame_rdy_release: got ready=%b sframes=%0d, required ready=1 sframes=1",
               bus.in_ready, n_sframe - sf0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_gaps();
    int sf0;
    sf0 = n_sframe;
    send_pixels(64, 24'h000000, 1'b1, 1'b1);
    wait_frame_done(sf0, "random_gaps");
  endtask

  task automatic test_mid_frame_reset();
    int s0, sf0;
    send_pixels(43, 24'h600000, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.fbw_wren, bus.fbw_row_swap, bus.fbw_row_store, bus.frame_swap,
         bus.stat_frame, bus.stat_resync, bus.fbw_bank_addr, bus.fbw_row_addr,
         bus.fbw_col_addr, bus.fbw_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b wren=%b col=%0d bank=%0d row=%0d data=%h, required all 0",
               bus.in_ready, bus.fbw_wren, bus.fbw_col_addr, bus.fbw_bank_addr, bus.fbw_row_addr, bus.fbw_data);
    end
    checks++;
    if (wq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending: got writes=%0d stores=%0d outstanding, required 0 0",
               wq.size(), sq.size());
    end
    rst = 1'b0;
    mline = 0;
    mcol = 0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    s0 = n_store; sf0 = n_sframe;
    send_pixels(64, 24'h700000, 1'b1, 1'b0);
    wait_frame_done(sf0, "midreset_frame");
    checks++;
    if (n_store - s0 != 8) begin
      errors++;
      $display("FAIL midreset_frame_stores: got %0d, required 8", n_store - s0);
    end
  endtask

  task automatic test_final();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (wq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got writes=%0d stores=%0d outstanding, required 0 0",
               wq.size(), sq.size());
    end
    checks++;
    if (n_fswap != exp_fswap || n_sframe != exp_fswap) begin
      errors++;
      $display("FAIL final_frames: got fswaps=%0d sframes=%0d, required %0d %0d",
               n_fswap, n_sframe, exp_fswap, exp_fswap);
    end
    checks++;
    if (n_resync != exp_resync) begin
      errors++;
      $display("FAIL final_resync: got %0d, required %0d", n_resync, exp_resync);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_row_rdy_stall();
    test_resync();
    test_frame_rdy_stall();
    test_random_gaps();
    test_mid_frame_reset();
    test_final();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
